// File: rtl/round_key_gen_dec.sv
// Iterative DES key-schedule engine: emits 16 round keys (K16..K1) per loaded post-PC-1 key.
// Optional KEY_SCHED_ENC_MODE_EN adds mode_i to select encryption order (K1..K16) instead.

module p_box_56_48 (
   input  logic [55:0] din,
   output logic [47:0] dout
);
   // PC-2 selection table, 1-based positions counted from the MSB of din
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   always_comb begin
      dout = '0;
      for (int i = 0; i < 48; i++) begin
         dout[47-i] = din[56-PC2[i]];
      end
   end
endmodule

module round_key_gen_dec #(
   parameter int unsigned NUM_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [55:0] key_i,
   input  logic        valid_i,
`ifdef KEY_SCHED_ENC_MODE_EN
   input  logic        mode_i,
`endif
   output logic        ready_o,
   output logic [47:0] round_key_o,
   output logic [3:0]  round_idx_o,
   output logic        key_valid_o,
   input  logic        key_ready_i,
   output logic        last_o
);
   localparam int unsigned HALF_W = 28;
   localparam int unsigned IDX_W  = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state;
   logic [HALF_W-1:0]   c_q, d_q;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    idx_next;
   logic                shift_two;
   logic [HALF_W-1:0]   c_next, d_next;
   logic                enc_sel;
   logic                enc_q;

   function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] x,
                                                  input logic two, input logic left);
      logic [HALF_W-1:0] r;
      if (left) r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
      else      r = two ? {x[1:0], x[27:2]}   : {x[0], x[27:1]};
      return r;
   endfunction

   // Steps 1, 8 and 15 shift by one; all other steps shift by two in either direction
   always_comb begin
      idx_next  = idx_q + IDX_W'(1);
      shift_two = !((idx_next == IDX_W'(1)) || (idx_next == IDX_W'(8)) ||
                    (idx_next == IDX_W'(15)));
      c_next    = rot_half(c_q, shift_two, enc_q);
      d_next    = rot_half(d_q, shift_two, enc_q);
   end

`ifdef KEY_SCHED_ENC_MODE_EN
   assign enc_sel = mode_i;
`else
   assign enc_sel = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         c_q         <= '0;
         d_q         <= '0;
         idx_q       <= '0;
         ready_o     <= 1'b1;
         key_valid_o <= 1'b0;
         enc_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i) begin
                  // Decrypt loads C0/D0 as-is (C16 == C0); encrypt pre-applies round 1's shift
                  c_q         <= enc_sel ? {key_i[54:28], key_i[55]} : key_i[55:28];
                  d_q         <= enc_sel ? {key_i[26:0], key_i[27]}  : key_i[27:0];
                  enc_q       <= enc_sel;
                  idx_q       <= '0;
                  state       <= RUN;
                  ready_o     <= 1'b0;
                  key_valid_o <= 1'b1;
               end
            end
            RUN: begin
               if (key_ready_i) begin
                  if (idx_q == LAST_IDX) begin
                     state       <= IDLE;
                     ready_o     <= 1'b1;
                     key_valid_o <= 1'b0;
                  end else begin
                     idx_q <= idx_next;
                     c_q   <= c_next;
                     d_q   <= d_next;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               ready_o     <= 1'b1;
               key_valid_o <= 1'b0;
            end
         endcase
      end
   end

   p_box_56_48 u_pc2 (
      .din  ({c_q, d_q}),
      .dout (round_key_o)
   );

   assign round_idx_o = idx_q;
   assign last_o      = key_valid_o && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_round_key_gen_dec.sv
// Self-checking bench for round_key_gen_dec; reference derives each round key from the
// cumulative encryption shift count. Define KEY_SCHED_ENC_MODE_EN to also cover encrypt order.

module tb_round_key_gen_dec;
   localparam logic [55:0] KNOWN_KEY = 56'hF0CCAAF556678F;
   localparam int ENC_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   logic        clk = 1'b0;
   logic        rst;
   logic [55:0] key_i;
   logic        valid_i;
   logic        mode_i;
   logic        ready_o;
   logic [47:0] round_key_o;
   logic [3:0]  round_idx_o;
   logic        key_valid_o;
   logic        key_ready_i;
   logic        last_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   round_key_gen_dec dut (
      .clk         (clk),
      .rst         (rst),
      .key_i       (key_i),
      .valid_i     (valid_i),
`ifdef KEY_SCHED_ENC_MODE_EN
      .mode_i      (mode_i),
`endif
      .ready_o     (ready_o),
      .round_key_o (round_key_o),
      .round_idx_o (round_idx_o),
      .key_valid_o (key_valid_o),
      .key_ready_i (key_ready_i),
      .last_o      (last_o)
   );

   // Round key K_r: halves rotated left by the sum of the first r shifts, then PC-2
   function automatic logic [47:0] model_key(input logic [55:0] k, input int r);
      int s;
      logic [27:0] c, d;
      logic [55:0] cd;
      logic [47:0] out;
      s = 0;
      for (int i = 0; i < r; i++) s += ENC_SH[i];
      s = s % 28;
      c = k[55:28];
      d = k[27:0];
      for (int i = 0; i < s; i++) begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
      end
      cd = {c, d};
      out = '0;
      for (int i = 0; i < 48; i++) out[47-i] = cd[56-PC2[i]];
      return out;
   endfunction

   task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Loads key and consumes all 16 round keys; call at a negedge.
   // ready_mode: 0 always ready, 1 one-of-three, 2 random.
   task automatic run_seq(input logic [55:0] key, input int ready_mode, input bit hold_valid,
                          input logic [55:0] alt_key, input bit enc);
      int guard;
      int hs;
      int cyc;
      int r;
      bit kr;
      logic [47:0] exp_k;
      guard = 0;
      while (!ready_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("ready_before_load", 56'(ready_o), 56'(1));
      key_i   = key;
      valid_i = 1'b1;
      mode_i  = enc;
      key_ready_i = 1'b0;
      @(negedge clk);
      if (hold_valid) key_i = alt_key;
      else valid_i = 1'b0;
      hs  = 0;
      cyc = 0;
      while (hs < 16 && cyc < 200) begin
         case (ready_mode)
            0:       kr = 1'b1;
            1:       kr = (cyc % 3 == 2);
            default: kr = 1'($urandom_range(0, 1));
         endcase
         key_ready_i = kr;
         r = enc ? hs + 1 : 16 - hs;
         exp_k = model_key(key, r);
         check("key_valid", 56'(key_valid_o), 56'(1));
         check("ready_busy", 56'(ready_o), 56'(0));
         check("round_idx", 56'(round_idx_o), 56'(hs));
         check("round_key", 56'(round_key_o), 56'(exp_k));
         check("last", 56'(last_o), 56'(hs == 15));
         if (key == KNOWN_KEY && (hs == 0 || hs == 14 || hs == 15)) begin
            if (!enc && hs == 0)  check("known_k16", 56'(round_key_o), 56'(48'hCB3D8B0E17F5));
            if (!enc && hs == 14) check("known_k2",  56'(round_key_o), 56'(48'h79AED9DBC9E5));
            if (!enc && hs == 15) check("known_k1",  56'(round_key_o), 56'(48'h1B02EFFC7072));
            if (enc && hs == 0)   check("enc_k1",    56'(round_key_o), 56'(48'h1B02EFFC7072));
            if (enc && hs == 15)  check("enc_k16",   56'(round_key_o), 56'(48'hCB3D8B0E17F5));
         end
         if (kr) hs++;
         cyc++;
         @(negedge clk);
      end
      if (cyc >= 200) check("handshake_timeout", 56'(hs), 56'(16));
      key_ready_i = 1'b0;
      check("ready_after_seq", 56'(ready_o), 56'(1));
      check("valid_after_seq", 56'(key_valid_o), 56'(0));
   endtask

   initial begin
      logic [55:0] rk;
      logic [55:0] alt;
      rst = 1'b1;
      valid_i = 1'b0;
      key_i = '0;
      key_ready_i = 1'b0;
      mode_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_ready", 56'(ready_o), 56'(1));
      check("rst_valid", 56'(key_valid_o), 56'(0));
      check("rst_key", 56'(round_key_o), 56'(0));
      check("rst_idx", 56'(round_idx_o), 56'(0));
      check("rst_last", 56'(last_o), 56'(0));

      run_seq(KNOWN_KEY, 0, 1'b0, '0, 1'b0);
      run_seq(KNOWN_KEY, 1, 1'b0, '0, 1'b0);

      alt = {24'($urandom), 32'($urandom)};
      run_seq(KNOWN_KEY, 2, 1'b1, alt, 1'b0);
      run_seq(alt, 2, 1'b0, '0, 1'b0);

      // Reset in the middle of a sequence
      rk = {24'($urandom), 32'($urandom)};
      key_i = rk;
      valid_i = 1'b1;
      key_ready_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      repeat (7) @(negedge clk);
      check("pre_rst_idx", 56'(round_idx_o), 56'(7));
      check("pre_rst_key", 56'(round_key_o), 56'(model_key(rk, 9)));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      key_ready_i = 1'b0;
      check("mid_rst_valid", 56'(key_valid_o), 56'(0));
      check("mid_rst_ready", 56'(ready_o), 56'(1));
      check("mid_rst_idx", 56'(round_idx_o), 56'(0));
      check("mid_rst_key", 56'(round_key_o), 56'(0));
      key_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      check("mid_rst_quiet", 56'(key_valid_o), 56'(0));
      key_ready_i = 1'b0;
      run_seq(KNOWN_KEY, 0, 1'b0, '0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         rk = {24'($urandom), 32'($urandom)};
         run_seq(rk, 2, 1'b0, '0, 1'b0);
      end

`ifdef KEY_SCHED_ENC_MODE_EN
      run_seq(KNOWN_KEY, 0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         rk = {24'($urandom), 32'($urandom)};
         run_seq(rk, 2, 1'b0, '0, 1'($urandom_range(0, 1)));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
